// File: rtl/output_channel_pkg.sv
// Purpose: shared flit types for the router datapath (tag, payload, packed flit).
// Latency: n/a (types and constants only).
// Backpressure: n/a.
// Contents: flit_tag_e, flit_t, FLIT_W, MAX_INPUTS, is_last_tag().
package output_channel_pkg;

    // Position of a flit within its packet.
    typedef enum logic [1:0] {
        FLIT_HEAD          = 2'd0,
        FLIT_BODY          = 2'd1,
        FLIT_TAIL          = 2'd2,
        FLIT_START_AND_END = 2'd3
    } flit_tag_e;

    typedef struct packed {
        flit_tag_e   tag;
        logic [15:0] payload;
    } flit_t;

    localparam int FLIT_W     = $bits(flit_t);
    localparam int MAX_INPUTS = 16;

    // True for the tags that close a packet; producers use this to build in_last.
    function automatic logic is_last_tag(input flit_tag_e tag);
        return (tag == FLIT_TAIL) || (tag == FLIT_START_AND_END);
    endfunction

endpackage

// File: rtl/output_channel_if.sv
// Purpose: bundle of the N routed flit streams into one egress port plus the outgoing link.
// Latency: n/a (wires only).
// Backpressure: valid/ready on each input stream and on the outgoing link.
// Ports: in_valid/in_ready/in_flit/in_last per input, out_valid/out_ready/out_flit, grant_active.
//        slave = the egress stage, master = whoever drives the inputs and sinks the link.
interface output_channel_if
    import output_channel_pkg::*;
#(
    parameter int N_INPUTS = 4
);
    logic  [N_INPUTS-1:0] in_valid;
    logic  [N_INPUTS-1:0] in_ready;
    flit_t [N_INPUTS-1:0] in_flit;
    logic  [N_INPUTS-1:0] in_last;
    logic                 out_valid;
    logic                 out_ready;
    flit_t                out_flit;
    logic                 grant_active;

    modport master (
        output in_valid, in_flit, in_last, out_ready,
        input  in_ready, out_valid, out_flit, grant_active
    );

    modport slave (
        input  in_valid, in_flit, in_last, out_ready,
        output in_ready, out_valid, out_flit, grant_active
    );
endinterface

// File: rtl/output_channel_skid_buffer.sv
// Purpose: two-entry registered stream buffer (head register drives the output, skid catches one more).
// Latency: 1 cycle from in handshake to out_valid; out_valid/out_data come straight from flops.
// Backpressure: in_ready = skid slot empty, a pure function of registered state (never of out_ready).
// Ports: clk, rst (async, active-high), in_valid/in_ready/in_data, out_valid/out_ready/out_data.
module stream_skid_buffer #(
    parameter type DATA_T = logic [7:0]
) (
    input  logic  clk,
    input  logic  rst,
    input  logic  in_valid,
    output logic  in_ready,
    input  DATA_T in_data,
    output logic  out_valid,
    input  logic  out_ready,
    output DATA_T out_data
);
    logic  head_vld;
    logic  skid_vld;
    DATA_T head_dat;
    DATA_T skid_dat;
    logic  push;
    logic  pop;

    // The skid slot only fills while the head is occupied, so "skid empty"
    // is exactly "fewer than two entries".
    assign in_ready  = !skid_vld;
    assign out_valid = head_vld;
    assign out_data  = head_dat;

    assign push = in_valid && in_ready;
    assign pop  = head_vld && out_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head_vld <= 1'b0;
            skid_vld <= 1'b0;
            head_dat <= '0;
            skid_dat <= '0;
        end else if (pop) begin
            // Older skid entry moves up first; a push cannot coincide with
            // a full buffer because in_ready is low then.
            if (skid_vld) begin
                head_dat <= skid_dat;
                skid_vld <= 1'b0;
            end else if (push) begin
                head_dat <= in_data;
            end else begin
                head_vld <= 1'b0;
            end
        end else if (push) begin
            if (!head_vld) begin
                head_dat <= in_data;
                head_vld <= 1'b1;
            end else begin
                skid_dat <= in_data;
                skid_vld <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/output_channel.sv
// Purpose: per-port egress stage; merges N routed flit streams with packet-granular round-robin.
// Latency: flit accepted in cycle t is on out_valid/out_flit in cycle t+1 (registered output).
// Backpressure: at most one in_ready bit, gated by buffer space (< 2 entries), independent of out_ready.
// Ports: clk, rst (async, active-high), bus (output_channel_if.slave): in_valid/in_ready/in_flit/
//        in_last per input, out_valid/out_ready/out_flit toward the link, grant_active = lock held.
module output_channel
    import output_channel_pkg::*;
#(
    parameter int N_INPUTS = 4
) (
    input logic             clk,
    input logic             rst,
    output_channel_if.slave bus
);
    localparam int IDX_W = $clog2(N_INPUTS);

    typedef enum logic {
        IDLE,
        LOCKED
    } state_t;

    state_t             state;
    logic [IDX_W-1:0]   rr_ptr;
    logic [IDX_W-1:0]   lock_idx;
    logic               grant_q;

    logic [N_INPUTS-1:0] rot_valid;
    logic [IDX_W-1:0]    rot_idx;
    logic [IDX_W:0]      idx_sum;
    logic [IDX_W-1:0]    arb_idx;
    logic [IDX_W-1:0]    cur_idx;
    logic                cur_vld;
    logic                cur_last;
    flit_t               cur_flit;
    logic                space;
    logic                push;

    function automatic logic [IDX_W-1:0] rr_next(input logic [IDX_W-1:0] idx);
        return (idx == IDX_W'(N_INPUTS - 1)) ? '0 : idx + IDX_W'(1);
    endfunction

    // Round-robin pick: rotate so rr_ptr sits at bit 0, take the lowest set
    // bit, then rotate the index back. With no valid input the result is
    // rr_ptr itself, whose valid bit is 0, so nothing is granted.
    always_comb begin
        rot_valid = N_INPUTS'({bus.in_valid, bus.in_valid} >> rr_ptr);
        rot_idx   = '0;
        for (int k = N_INPUTS - 1; k >= 0; k--) begin
            if (rot_valid[k]) begin
                rot_idx = IDX_W'(k);
            end
        end
        idx_sum = {1'b0, rot_idx} + {1'b0, rr_ptr};
        if (idx_sum >= (IDX_W + 1)'(N_INPUTS)) begin
            idx_sum = idx_sum - (IDX_W + 1)'(N_INPUTS);
        end
        arb_idx = idx_sum[IDX_W-1:0];
    end

    // While locked the owner is served exclusively, even when it idles.
    always_comb begin
        cur_idx  = (state == LOCKED) ? lock_idx : arb_idx;
        cur_vld  = bus.in_valid[cur_idx];
        cur_last = bus.in_last[cur_idx];
        cur_flit = bus.in_flit[cur_idx];
        push     = cur_vld && space;

        bus.in_ready = '0;
        // A locked owner sees ready whenever there is room; in IDLE ready is
        // only offered to the input actually selected. Held low during reset.
        if (!rst && space && ((state == LOCKED) || cur_vld)) begin
            bus.in_ready[cur_idx] = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            rr_ptr   <= '0;
            lock_idx <= '0;
            grant_q  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (push) begin
                        if (cur_last) begin
                            // Single-flit packet: arbitration and transfer in one cycle.
                            rr_ptr <= rr_next(arb_idx);
                        end else begin
                            state    <= LOCKED;
                            lock_idx <= arb_idx;
                            grant_q  <= 1'b1;
                        end
                    end
                end
                LOCKED: begin
                    if (push && cur_last) begin
                        state   <= IDLE;
                        grant_q <= 1'b0;
                        rr_ptr  <= rr_next(lock_idx);
                    end
                end
                default: begin
                    state   <= IDLE;
                    grant_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.grant_active = grant_q;

    stream_skid_buffer #(
        .DATA_T (flit_t)
    ) u_skid (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (cur_vld),
        .in_ready  (space),
        .in_data   (cur_flit),
        .out_valid (bus.out_valid),
        .out_ready (bus.out_ready),
        .out_data  (bus.out_flit)
    );

endmodule

// File: doc/output_channel.md
# output_channel

Per-port egress stage of the router. It merges up to N_INPUTS routed flit streams whose target is this port into one outgoing flit stream. Arbitration is round-robin at packet granularity (wormhole): an input keeps the grant from its head flit until its `last` flit is accepted. It is the consumer end of the routed-flit interface that input channels produce, and drives the link toward the next router or endpoint.

## Interface
- N_INPUTS, 4: number of contending input channels, 2..16.
- FLIT_W, $bits(flit_t): flit payload width.
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-high.
- in_valid  in  N_INPUTS  per-input valid, already qualified by target == this port.
- in_ready  out  N_INPUTS  per-input ready, at most one bit set per cycle.
- in_flit  in  N_INPUTS×FLIT_W  per-input flit (flit_t, includes tag).
- in_last  in  N_INPUTS  flit ends its packet (tag TAIL or START_AND_END).
- out_valid  out  1  outgoing flit valid, driven from a register.
- out_ready  in  1  downstream ready; may depend on out_valid.
- out_flit  out  FLIT_W  outgoing flit, driven from a register.
- grant_active  out  1  a packet is mid-transfer (lock held).

## Operation
- States: IDLE (no lock) and LOCKED(g).
- IDLE:
  - Select the first valid input at or after rr_ptr, searching upward modulo N_INPUTS.
  - Set in_ready[sel] = space; all other in_ready bits are 0.
  - On handshake with in_last=1: stay IDLE, rr_ptr ← sel+1 mod N_INPUTS.
  - On handshake with in_last=0: go to LOCKED(sel).
  - No valid inputs: all in_ready bits are 0 and state is unchanged.
- LOCKED(g):
  - in_ready[g] = space; all other in_ready bits are 0.
  - If in_valid[g] drops, the lock holds and no other input is served.
  - On handshake with in_last=1: go to IDLE, rr_ptr ← g+1.
- `space` = skid buffer holds fewer than 2 entries. It never depends combinationally on out_ready.
- Accepted flits pass unmodified and in order. The flits of one packet are never interleaved with another packet's.
- grant_active = state is LOCKED.
- No tag checking. in_last alone defines packet boundaries.

## Timing
- Reset state: IDLE, rr_ptr=0, buffer empty, out_valid=0, out_flit=0, grant_active=0, in_ready all 0 in the reset cycle.
- Latency: a flit accepted in cycle t appears on out_valid/out_flit in cycle t+1.
- Throughput:
  - 1 flit/cycle sustained while out_ready=1.
  - A packet switch (input A's last flit in cycle t, input B's head flit in cycle t+1) has no bubble.
  - A single-flit packet in IDLE takes arbitration and transfer in the same cycle.
- Back-pressure:
  - out_ready=0 while the buffer holds 1 entry: one more flit is accepted into the skid slot, then space=0.
  - When out_ready returns, the skid entry drains first; ordering is preserved.
- Output holds: out_valid && !out_ready means out_valid and out_flit stay stable next cycle.
- Simultaneous pop and push with a full buffer: not possible, because space=0 blocks the push.
- Reset mid-packet:
  - The lock is dropped and buffered flits are discarded.
  - Upstream channels are reset by the same rst.

## Structure
- flit_t and flit_tag live in the shared flit package. No new package types.
- Sub-module stream_skid_buffer:
  - Two-entry registered buffer; parameter DATA_T.
  - Ports: in_valid/in_ready/in_data, out_valid/out_ready/out_data.
  - in_ready depends only on registered occupancy.
- Round-robin select is local combinational logic: rotate, priority-encode, rotate back. A separate module is not required.

## Test plan
- Reset, then input 2 sends a 3-flit packet (HEAD, BODY, TAIL) with out_ready=1:
  - out_flit matches in cycles 1, 2, 3.
  - grant_active is high only between the HEAD and TAIL handshakes.
  - rr_ptr becomes 3.
- Inputs 0 and 1 both present 2-flit packets from cycle 0:
  - Output order is 0H, 0T, 1H, 1T with no bubble.
  - in_ready[1] stays 0 until input 0's TAIL is accepted.
- All 4 inputs send continuous START_AND_END flits:
  - Grant order is 0, 1, 2, 3, 0, …; out_valid is high every cycle from cycle 1.
  - Each input receives exactly 25% of handshakes over 40 cycles.
- Input 1 sends a HEAD, then in_valid[1]=0 for 5 cycles while input 3 is valid:
  - No input-3 flit is output until input 1's TAIL has passed.
- out_ready toggles randomly (≈50%) during a 10-flit packet:
  - All 10 flits arrive in order with no loss or duplication.
  - out_flit is stable whenever it is stalled.
  - in_ready never depends combinationally on out_ready.
- rst asserted mid-packet, after 2 of 4 flits:
  - out_valid=0 and grant_active=0 immediately.
  - After release, a new packet from input 3 is granted.
